// File: rtl/spike_rate_decoder.sv
// Spike train decoder: windowed rising-edge rate counter plus inter-spike interval meter.
// Optional EMA of the rate (output rate_avg) is built when SPIKE_DECODER_EMA_EN is defined.
module spike_rate_decoder #(
    parameter int WINDOW_LOG2 = 4,
    parameter int CNT_W       = 8,
    parameter int ISI_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             spike,
    input  logic             clear,
    output logic [CNT_W-1:0] rate,
    output logic             rate_valid,
    output logic [ISI_W-1:0] isi,
    output logic             isi_valid,
    output logic             armed
`ifdef SPIKE_DECODER_EMA_EN
    ,
    output logic [CNT_W-1:0] rate_avg
`endif
);

    // rate_valid / isi_valid are one-cycle strobes with no backpressure; rate and isi
    // stay stable between strobes, so a consumer may sample them on the strobe or later.
    typedef enum logic {ST_IDLE = 1'b0, ST_ARMED = 1'b1} isi_state_t;

    isi_state_t             r_state;
    isi_state_t             w_state_next;
    logic                   r_spike_q;
    logic [WINDOW_LOG2-1:0] r_win_cnt;
    logic [CNT_W-1:0]       r_spike_acc;
    logic [ISI_W-1:0]       r_isi_cnt;
    logic [CNT_W-1:0]       r_rate;
    logic [ISI_W-1:0]       r_isi;
    logic                   r_rate_valid;
    logic                   r_isi_valid;

    logic                   w_event;
    logic                   w_win_end;
    logic [CNT_W-1:0]       w_acc_inc;
    logic [CNT_W-1:0]       w_rate_next;
    logic [ISI_W-1:0]       w_isi_inc;

    assign w_event     = spike & ~r_spike_q & en & ~clear;
    assign w_win_end   = en && (r_win_cnt == {WINDOW_LOG2{1'b1}});
    assign w_acc_inc   = (r_spike_acc == {CNT_W{1'b1}}) ? r_spike_acc : r_spike_acc + 1'b1;
    // An event on the last window cycle still belongs to the window that is closing.
    assign w_rate_next = w_event ? w_acc_inc : r_spike_acc;
    assign w_isi_inc   = (r_isi_cnt == {ISI_W{1'b1}}) ? r_isi_cnt : r_isi_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = ST_IDLE;
        end else if (r_state == ST_IDLE && w_event) begin
            w_state_next = ST_ARMED;
        end
    end

    always_comb begin
        armed = (r_state == ST_ARMED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_spike_q    <= 1'b0;
            r_win_cnt    <= '0;
            r_spike_acc  <= '0;
            r_isi_cnt    <= '0;
            r_rate       <= '0;
            r_isi        <= '0;
            r_rate_valid <= 1'b0;
            r_isi_valid  <= 1'b0;
        end else begin
            r_spike_q    <= spike;
            r_rate_valid <= 1'b0;
            r_isi_valid  <= 1'b0;
            if (clear) begin
                r_win_cnt   <= '0;
                r_spike_acc <= '0;
                r_isi_cnt   <= '0;
            end else if (en) begin
                r_win_cnt <= r_win_cnt + 1'b1;
                if (w_win_end) begin
                    r_rate       <= w_rate_next;
                    r_spike_acc  <= '0;
                    r_rate_valid <= 1'b1;
                end else if (w_event) begin
                    r_spike_acc <= w_acc_inc;
                end
                // The first event after IDLE only starts the interval; later ones report it.
                if (w_event) begin
                    r_isi_cnt <= '0;
                    if (r_state == ST_ARMED) begin
                        r_isi       <= w_isi_inc;
                        r_isi_valid <= 1'b1;
                    end
                end else if (r_state == ST_ARMED) begin
                    r_isi_cnt <= w_isi_inc;
                end
            end
        end
    end

    assign rate       = r_rate;
    assign rate_valid = r_rate_valid;
    assign isi        = r_isi;
    assign isi_valid  = r_isi_valid;

`ifdef SPIKE_DECODER_EMA_EN
    logic [CNT_W-1:0]       r_rate_avg;
    logic signed [CNT_W:0]  w_ema_diff;
    logic signed [CNT_W:0]  w_ema_sum;

    // Alpha = 1/4 exponential average, signed one bit wider so the step can be negative.
    assign w_ema_diff = $signed({1'b0, w_rate_next}) - $signed({1'b0, r_rate_avg});
    assign w_ema_sum  = $signed({1'b0, r_rate_avg}) + (w_ema_diff >>> 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rate_avg <= '0;
        end else if (!clear && w_win_end) begin
            r_rate_avg <= w_ema_sum[CNT_W-1:0];
        end
    end

    assign rate_avg = r_rate_avg;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: expected rate/isi values are queued by the
// stimulus thread and consumed by a monitor whenever the DUT strobes a valid.
module tb_spike_rate_decoder;

  localparam int WINDOW_LOG2 = 4;
  localparam int CNT_W       = 3;
  localparam int ISI_W       = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             spike = 1'b0;
  logic             clear = 1'b0;
  logic [CNT_W-1:0] rate;
  logic             rate_valid;
  logic [ISI_W-1:0] isi;
  logic             isi_valid;
  logic             armed;
`ifdef SPIKE_DECODER_EMA_EN
  logic [CNT_W-1:0] rate_avg;
  logic [CNT_W-1:0] avg_model = '0;
`endif

  logic [CNT_W-1:0] exp_rate_q[$];
  logic [ISI_W-1:0] exp_isi_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  spike_rate_decoder #(
    .WINDOW_LOG2(WINDOW_LOG2),
    .CNT_W(CNT_W),
    .ISI_W(ISI_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .spike(spike),
    .clear(clear),
    .rate(rate),
    .rate_valid(rate_valid),
    .isi(isi),
    .isi_valid(isi_valid),
    .armed(armed)
`ifdef SPIKE_DECODER_EMA_EN
    ,
    .rate_avg(rate_avg)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // driver: apply one cycle of inputs, return 1 time unit after the sampling edge
  task automatic drive(input logic s, input logic e, input logic c);
    spike = s;
    en    = e;
    clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic push_rate(input logic [CNT_W-1:0] v);
    exp_rate_q.push_back(v);
  endtask

  task automatic push_isi(input logic [ISI_W-1:0] v);
    exp_isi_q.push_back(v);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && rate_valid) begin
      if (exp_rate_q.size() == 0) begin
        check("unexpected_rate_valid", 32'(rate_valid), 32'd0);
      end else begin
        logic [CNT_W-1:0] e_rate;
        e_rate = exp_rate_q.pop_front();
        check("rate", 32'(rate), 32'(e_rate));
`ifdef SPIKE_DECODER_EMA_EN
        begin
          logic signed [CNT_W:0] d;
          logic signed [CNT_W:0] s;
          d = $signed({1'b0, e_rate}) - $signed({1'b0, avg_model});
          s = $signed({1'b0, avg_model}) + (d >>> 2);
          avg_model = s[CNT_W-1:0];
          check("rate_avg", 32'(rate_avg), 32'(avg_model));
        end
`endif
      end
    end
    if (!rst && isi_valid) begin
      if (exp_isi_q.size() == 0) begin
        check("unexpected_isi_valid", 32'(isi_valid), 32'd0);
      end else begin
        check("isi", 32'(isi), 32'(exp_isi_q.pop_front()));
      end
    end
  end

  initial begin
    // reset with spike toggling
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    check("rst_rate", 32'(rate), 32'd0);
    check("rst_isi", 32'(isi), 32'd0);
    drive(1'b0, 1'b1, 1'b0);
    check("rst_armed", 32'(armed), 32'd0);
    check("rst_rate_valid", 32'(rate_valid), 32'd0);
    check("rst_isi_valid", 32'(isi_valid), 32'd0);
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0);
    check("post_rst_rate_valid", 32'(rate_valid), 32'd0);
    check("post_rst_isi_valid", 32'(isi_valid), 32'd0);
    check("post_rst_armed", 32'(armed), 32'd0);

    // rate: pulses every 4 cycles; second window has its last pulse on cycle 15
    drive(1'b0, 1'b1, 1'b1);
    push_rate(3'd4); push_rate(3'd4);
    push_isi(8'd4); push_isi(8'd4); push_isi(8'd4); push_isi(8'd7);
    push_isi(8'd4); push_isi(8'd4); push_isi(8'd4);
    for (int p = 0; p < 32; p++) begin
      drive((p < 16) ? (p % 4 == 0) : (p % 4 == 3), 1'b1, 1'b0);
    end
    check("armed_after_rate", 32'(armed), 32'd1);

    // isi: pulses at cycles 10, 17, 20
    drive(1'b0, 1'b1, 1'b1);
    check("clear_disarms", 32'(armed), 32'd0);
    push_rate(3'd1); push_rate(3'd2);
    push_isi(8'd7); push_isi(8'd3);
    for (int p = 0; p < 32; p++) begin
      drive(p == 10 || p == 17 || p == 20, 1'b1, 1'b0);
      if (p == 9)  check("armed_before_first", 32'(armed), 32'd0);
      if (p == 10) check("armed_after_first", 32'(armed), 32'd1);
    end

    // rate saturation: 8 edges in a window with CNT_W=3
    drive(1'b0, 1'b1, 1'b1);
    push_rate(3'd7);
    for (int i = 0; i < 7; i++) push_isi(8'd2);
    for (int p = 0; p < 16; p++) drive(p % 2 == 0, 1'b1, 1'b0);

    // isi saturation: pulses 300 cycles apart
    drive(1'b0, 1'b1, 1'b1);
    push_rate(3'd1);
    for (int i = 0; i < 17; i++) push_rate(3'd0);
    push_rate(3'd1); push_rate(3'd0);
    push_isi(8'd255);
    for (int p = 0; p < 320; p++) drive(p == 0 || p == 300, 1'b1, 1'b0);

    // spike held high for 40 cycles is one event
    drive(1'b0, 1'b1, 1'b1);
    push_rate(3'd1); push_rate(3'd0); push_rate(3'd0);
    for (int p = 0; p < 48; p++) drive(p < 40, 1'b1, 1'b0);
    check("armed_after_held", 32'(armed), 32'd1);

    // enable: 5 frozen cycles inside the interval, edge during freeze is lost
    drive(1'b0, 1'b1, 1'b1);
    push_isi(8'd12); push_rate(3'd2);
    drive(1'b1, 1'b1, 1'b0);
    repeat (5) drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    repeat (5) drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b1, 1'b0);

    // clear mid-window with three counted edges; rising edge on the clear cycle is dropped
    push_isi(8'd4); push_isi(8'd2); push_isi(8'd2);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    check("clear_rate_hold", 32'(rate), 32'd2);
    check("clear_isi_hold", 32'(isi), 32'd2);
    check("clear_armed", 32'(armed), 32'd0);
    push_rate(3'd2); push_isi(8'd5);
    for (int p = 0; p < 16; p++) drive(p == 1 || p == 6, 1'b1, 1'b0);

    repeat (4) drive(1'b0, 1'b1, 1'b0);
    check("rate_q_drained", 32'(exp_rate_q.size()), 32'd0);
    check("isi_q_drained", 32'(exp_isi_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
